// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// stretches memory states on mem_ready, counts retired instructions, flags faults.
module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned INSTR_CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   enable,
  input  logic [6:0]             opcode,
  input  logic                   mem_ready,
  output logic [3:0]             state,
  output logic                   pc_write,
  output logic                   branch,
  output logic                   jump,
  output logic                   ir_write,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             alu_op,
  output logic                   mem_2_reg,
  output logic                   reg_write,
  output logic                   error,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       jump;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_2_reg;
    logic       reg_write;
    logic       error;
  } ctrl_t;

  state_e                 state_q, state_d;
  logic                   is_imm_q, is_imm_d;
  logic                   is_store_q, is_store_d;
  logic [TO_W-1:0]        cnt_q, cnt_d;
  logic [INSTR_CNT_W-1:0] count_q, count_d;
  ctrl_t                  ctrl_q;
  logic                   retire;
  logic                   wait_st;
  logic                   fetch_done;

  // Moore control word for a given state; registered against the next state
  function automatic ctrl_t ctrl_for(state_e s, logic imm);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b10;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.mem_2_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        c.alu_src_b = imm ? 2'b10 : 2'b00;
      end
      S_ALU_WB:   c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JUMP: begin
        c.jump     = 1'b1;
        c.pc_write = 1'b1;
      end
      S_ERROR:    c.error = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Next-state, class flags, timeout counter and retire accounting
  always_comb begin
    state_d    = state_q;
    is_imm_d   = is_imm_q;
    is_store_d = is_store_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    retire     = 1'b0;
    wait_st    = 1'b0;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_FETCH;
      S_FETCH: begin
        wait_st = 1'b1;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        is_imm_d   = (opcode == OP_ALU_I);
        is_store_d = (opcode == OP_STORE);
        case (opcode)
          OP_ALU_R, OP_ALU_I: state_d = S_EXEC;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JUMP:            state_d = S_JUMP;
          default:            state_d = S_ERROR;
        endcase
      end
      S_EXEC:     state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        wait_st = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        wait_st = 1'b1;
        retire  = mem_ready;
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
    if (retire) begin
      state_d = enable ? S_FETCH : S_IDLE;
      count_d = count_q + INSTR_CNT_W'(1);
    end
    // mem_ready on the final allowed cycle still completes normally
    if (TO_EN && wait_st && !mem_ready && (cnt_q == TO_LAST)) state_d = S_ERROR;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !mem_ready) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_IDLE;
      is_imm_q   <= 1'b0;
      is_store_q <= 1'b0;
      cnt_q      <= '0;
      count_q    <= '0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      is_imm_q   <= is_imm_d;
      is_store_q <= is_store_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_for(state_d, is_imm_d);
    end
  end

  // IR latch and PC+4 happen only in the fetch cycle that memory completes
  assign fetch_done  = (state_q == S_FETCH) && mem_ready;
  assign ir_write    = fetch_done;
  assign pc_write    = ctrl_q.pc_write | fetch_done;
  assign state       = state_q;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign i_or_d      = ctrl_q.i_or_d;
  assign mem_read    = ctrl_q.mem_read;
  assign mem_write   = ctrl_q.mem_write;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign alu_op      = ctrl_q.alu_op;
  assign mem_2_reg   = ctrl_q.mem_2_reg;
  assign reg_write   = ctrl_q.reg_write;
  assign error       = ctrl_q.error;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference model builds the
// expected per-cycle state/control sequence; randomized waits, enables and opcodes.
module tb_multicycle_control_unit;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 16;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JUMP   = 7'b1101111;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          enable;
  logic [6:0]    opcode;
  logic          mem_ready;
  logic [3:0]    state;
  logic          pc_write, branch, jump, ir_write, i_or_d, mem_read, mem_write;
  logic          alu_src_a, mem_2_reg, reg_write, error;
  logic [1:0]    alu_src_b, alu_op;
  logic [CW-1:0] instr_count;

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;

  int q_st[$];
  bit q_mr[$];
  bit q_ret[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .INSTR_CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .opcode(opcode), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .branch(branch), .jump(jump), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_2_reg(mem_2_reg), .reg_write(reg_write),
    .error(error), .instr_count(instr_count)
  );

  // Control word the specification lists for each state
  function automatic logic [14:0] exp_ctrl(int st, bit imm, bit mr);
    logic pcw, br, jp, irw, iod, mrd, mwr, sa, m2r, rw, er;
    logic [1:0] sb, aop;
    {pcw, br, jp, irw, iod, mrd, mwr, sa, m2r, rw, er} = '0;
    sb = 2'b00;
    aop = 2'b00;
    case (st)
      1:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      2:  sb = 2'b10;
      3:  begin sa = 1; sb = 2'b10; end
      4:  begin iod = 1; mrd = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin iod = 1; mwr = 1; end
      7:  begin sa = 1; aop = 2'b10; sb = imm ? 2'b10 : 2'b00; end
      8:  rw = 1;
      9:  begin sa = 1; aop = 2'b01; br = 1; end
      10: begin jp = 1; pcw = 1; end
      11: er = 1;
      default: ;
    endcase
    return {pcw, br, jp, irw, iod, mrd, mwr, sa, sb, aop, m2r, rw, er};
  endfunction

  function automatic void push(int st, bit mr, bit ret);
    q_st.push_back(st);
    q_mr.push_back(mr);
    q_ret.push_back(ret);
  endfunction

  // Expected cycle sequence of one legal instruction, starting in FETCH
  function automatic void build(logic [6:0] op, int fw, int mw);
    q_st.delete(); q_mr.delete(); q_ret.delete();
    for (int i = 0; i < fw; i++) push(1, 1'b0, 1'b0);
    push(1, 1'b1, 1'b0);
    push(2, 1'($urandom), 1'b0);
    case (op)
      OP_ALU_R, OP_ALU_I: begin push(7, 1'($urandom), 1'b0); push(8, 1'($urandom), 1'b1); end
      OP_LOAD: begin
        push(3, 1'($urandom), 1'b0);
        for (int i = 0; i < mw; i++) push(4, 1'b0, 1'b0);
        push(4, 1'b1, 1'b0);
        push(5, 1'($urandom), 1'b1);
      end
      OP_STORE: begin
        push(3, 1'($urandom), 1'b0);
        for (int i = 0; i < mw; i++) push(6, 1'b0, 1'b0);
        push(6, 1'b1, 1'b1);
      end
      OP_BRANCH: push(9, 1'($urandom), 1'b1);
      default:   push(10, 1'($urandom), 1'b1);
    endcase
  endfunction

  function automatic logic [6:0] rand_legal();
    logic [6:0] ops [6];
    ops = '{OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP};
    return ops[$urandom_range(0, 5)];
  endfunction

  task automatic sample(output logic [3:0] st, output logic [14:0] ct, output logic [CW-1:0] ic);
    st = state;
    ct = {pc_write, branch, jump, ir_write, i_or_d, mem_read, mem_write, alu_src_a,
          alu_src_b, alu_op, mem_2_reg, reg_write, error};
    ic = instr_count;
  endtask

  task automatic cycle(input bit mr, input bit en, input logic [6:0] op,
                       output logic [3:0] st, output logic [14:0] ct, output logic [CW-1:0] ic);
    @(negedge clk);
    mem_ready = mr;
    enable    = en;
    opcode    = op;
    #1;
    sample(st, ct, ic);
  endtask

  task automatic test_reset();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    @(negedge clk);
    arst_n = 1'b0; enable = 1'b1; mem_ready = 1'b1; opcode = OP_ALU_R;
    #1;
    sample(st, ct, ic);
    total++;
    if (st !== 4'd0 || ct !== 15'd0 || ic !== '0) begin
      bad++;
      $display("FAIL reset_async state=%0d want 0 ctrl=%b want 0 cnt=%0d want 0", st, ct, ic);
    end
    @(negedge clk);
    #1;
    sample(st, ct, ic);
    total++;
    if (st !== 4'd0 || ct !== 15'd0 || ic !== '0) begin
      bad++;
      $display("FAIL reset_hold state=%0d want 0 ctrl=%b want 0 cnt=%0d want 0", st, ct, ic);
    end
    arst_n = 1'b1;
    mem_ready = 1'($urandom);
    #1;
    sample(st, ct, ic);
    total++;
    if (st !== 4'd0 || ct !== 15'd0 || ic !== '0) begin
      bad++;
      $display("FAIL reset_idle state=%0d want 0 ctrl=%b want 0 cnt=%0d want 0", st, ct, ic);
    end
    m_cnt = 0;
  endtask

  task automatic test_alu_r();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    build(OP_ALU_R, 0, 0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], q_ret[i] ? 1'b1 : 1'($urandom), (q_st[i] == 1) ? 7'($urandom) : OP_ALU_R, st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL alu_r cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
      if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic test_load_wait();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    build(OP_LOAD, 0, 3);
    total++;
    if (q_st.size() != 8) begin
      bad++;
      $display("FAIL load_len cycles=%0d want 8", q_st.size());
    end
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], q_ret[i] ? 1'b1 : 1'($urandom), (q_st[i] == 1) ? 7'($urandom) : OP_LOAD, st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL load_wait cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
      if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic test_random_mix();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    logic [6:0] op;
    for (int n = 0; n < 24; n++) begin
      op = rand_legal();
      build(op, $urandom_range(0, 4), $urandom_range(0, 5));
      for (int i = 0; i < q_st.size(); i++) begin
        cycle(q_mr[i], q_ret[i] ? 1'b1 : 1'($urandom), (q_st[i] == 1) ? 7'($urandom) : op, st, ct, ic);
        total++;
        if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], op == OP_ALU_I, q_mr[i]) || ic !== CW'(m_cnt)) begin
          bad++;
          $display("FAIL random op=%b cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                   op, i, st, q_st[i], ct, exp_ctrl(q_st[i], op == OP_ALU_I, q_mr[i]), ic, m_cnt);
        end
        if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  endtask

  // Waits of TO-1 cycles complete because mem_ready wins on the last allowed cycle
  task automatic test_timeout_edge();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    logic [6:0] ops [2];
    ops = '{OP_STORE, OP_LOAD};
    for (int k = 0; k < 2; k++) begin
      build(ops[k], TO - 1, TO - 1);
      for (int i = 0; i < q_st.size(); i++) begin
        cycle(q_mr[i], 1'b1, ops[k], st, ct, ic);
        total++;
        if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
          bad++;
          $display("FAIL timeout_edge k=%0d cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                   k, i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
        end
        if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    build(OP_ALU_I, 0, 0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], (q_st[i] >= 7) ? 1'b0 : 1'b1, OP_ALU_I, st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b1, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL enable_drop cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b1, q_mr[i]), ic, m_cnt);
      end
      if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'($urandom), (i == 3), 7'($urandom), st, ct, ic);
      total++;
      if (st !== 4'd0 || ct !== 15'd0 || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL idle_hold cyc=%0d state=%0d want 0 ctrl=%b want 0 cnt=%0d want %0d", i, st, ct, ic, m_cnt);
      end
    end
  endtask

  task automatic test_store_timeout();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    q_st.delete(); q_mr.delete(); q_ret.delete();
    push(1, 1'b1, 1'b0); push(2, 1'b0, 1'b0); push(3, 1'b1, 1'b0);
    for (int i = 0; i < TO; i++) push(6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push(11, 1'($urandom), 1'b0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], 1'($urandom), OP_STORE, st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL store_timeout cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    q_st.delete(); q_mr.delete(); q_ret.delete();
    for (int i = 0; i < TO; i++) push(1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(11, 1'($urandom), 1'b0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], 1'b1, 7'($urandom), st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL fetch_timeout cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    logic [6:0] op;
    // Retire one instruction first so the frozen count is non-zero
    build(OP_JUMP, 1, 0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], 1'b1, OP_JUMP, st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL jump cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
      if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    op = 7'b1111111;
    q_st.delete(); q_mr.delete(); q_ret.delete();
    push(1, 1'b1, 1'b0); push(2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push(11, 1'($urandom), 1'b0);
    for (int i = 0; i < q_st.size(); i++) begin
      cycle(q_mr[i], 1'($urandom), (q_st[i] == 2) ? op : rand_legal(), st, ct, ic);
      total++;
      if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
        bad++;
        $display("FAIL illegal cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                 i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
      end
    end
  endtask

  task automatic test_branch_wrap();
    logic [3:0] st; logic [14:0] ct; logic [CW-1:0] ic;
    for (int n = 0; n < 17; n++) begin
      build(OP_BRANCH, $urandom_range(0, 1), 0);
      for (int i = 0; i < q_st.size(); i++) begin
        cycle(q_mr[i], 1'b1, (q_st[i] == 1) ? 7'($urandom) : OP_BRANCH, st, ct, ic);
        total++;
        if (st !== 4'(q_st[i]) || ct !== exp_ctrl(q_st[i], 1'b0, q_mr[i]) || ic !== CW'(m_cnt)) begin
          bad++;
          $display("FAIL branch n=%0d cyc=%0d state=%0d want %0d ctrl=%b want %b cnt=%0d want %0d",
                   n, i, st, q_st[i], ct, exp_ctrl(q_st[i], 1'b0, q_mr[i]), ic, m_cnt);
        end
        if (q_ret[i]) m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
    cycle(1'b0, 1'b1, OP_BRANCH, st, ct, ic);
    total++;
    if (st !== 4'd1 || ic !== CW'(1)) begin
      bad++;
      $display("FAIL branch_wrap state=%0d want 1 cnt=%0d want 1", st, ic);
    end
  endtask

  initial begin
    arst_n = 1'b1; enable = 1'b0; mem_ready = 1'b0; opcode = '0;
    test_reset();
    test_alu_r();
    test_load_wait();
    test_random_mix();
    test_timeout_edge();
    test_enable_drop();
    test_alu_r();
    test_store_timeout();
    test_reset();
    test_illegal();
    test_reset();
    test_fetch_timeout();
    test_reset();
    test_branch_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
